// File: rtl/cp0_exc_unit.sv
// CP0 for the 5-stage MIPS pipeline: SR/Cause/EPC/PRId, interrupt vs exception
// arbitration at M, the IntExc flush request and mfc0/mtc0 access.
module cp0_exc_unit #(
  parameter logic [31:0] PRID          = 32'h4C55_0007,
  parameter logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  EXCIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntExc,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  always_comb begin
    int_req    = (|(HWInt & im_q)) & ie_q & ~exl_q;
    exc_req    = (EXCIn != 5'd0) & ~exl_q;
    IntExc     = int_req | exc_req;

    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (IntExc) begin
      // The trapped instruction must not commit its own mtc0/eret effects.
      exl_d      = 1'b1;
      bd_d       = BD_M;
      epc_d      = (BD_M ? PC_M - 32'd4 : PC_M) & PC_ALIGN_MASK;
      exc_code_d = int_req ? 5'd0 : EXCIn;
    end else begin
      if (We && A2 == REG_SR) begin
        im_d  = DIn[15:10];
        exl_d = DIn[1];
        ie_d  = DIn[0];
      end
      if (We && A2 == REG_EPC) begin
        epc_d = DIn & PC_ALIGN_MASK;
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_comb begin
    sr_word    = {16'h0, im_q, 8'h0, exl_q, ie_q};
    cause_word = {bd_q, 15'h0, ip_q, 3'h0, exc_code_q, 2'h0};
    DOut       = 32'h0;
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'h0;
    endcase
  end

  assign EPC = epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: word-level CP0 model compared every negedge, plus
// hand-computed checkpoints from the directed scenarios.
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID = 32'h4C55_0007;
  localparam logic [31:0] MASK = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, EXCIn;
  logic [31:0] DIn, PC_M;
  logic        We, BD_M, EXLClr;
  logic [5:0]  HWInt;
  logic        IntExc;
  logic [31:0] EPC, DOut;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_exc_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We),
    .PC_M(PC_M), .BD_M(BD_M), .EXCIn(EXCIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .IntExc(IntExc), .EPC(EPC), .DOut(DOut)
  );

  always #5 clk = ~clk;

  // Model: architectural registers kept as plain 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;
  bit          m_valid = 0;

  function automatic bit m_irq();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_take();
    return m_irq() || ((EXCIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_valid = 1;
    end else if (m_valid) begin
      logic [31:0] pc_eff;
      if (m_take()) begin
        pc_eff  = BD_M ? PC_M - 32'd4 : PC_M;
        m_cause = {BD_M, 15'h0, HWInt, 3'h0, (m_irq() ? 5'd0 : EXCIn), 2'h0};
        m_sr    = m_sr | 32'h2;
        m_epc   = pc_eff & MASK;
      end else begin
        m_cause = (m_cause & ~32'h0000_FC00) | {16'h0, HWInt, 10'h0};
        if (We && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
        if (We && A2 == 5'd14) m_epc = DIn & MASK;
        if (EXLClr) m_sr = m_sr & ~32'h2;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks += 3;
      if (IntExc !== m_take()) begin
        n_fail++;
        $display("FAIL model_intexc t=%0t got %b want %b", $time, IntExc, m_take());
      end
      if (EPC !== m_epc) begin
        n_fail++;
        $display("FAIL model_epc t=%0t got %h want %h", $time, EPC, m_epc);
      end
      if (DOut !== m_read(A1)) begin
        n_fail++;
        $display("FAIL model_dout a1=%0d t=%0t got %h want %h", A1, $time, DOut, m_read(A1));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    chk(name, DOut, exp);
  endtask

  task automatic idle();
    We = 0; A2 = 0; DIn = 0; EXCIn = 0; EXLClr = 0; BD_M = 0;
  endtask

  initial begin
    reset = 1; A1 = 0; HWInt = 0; PC_M = 0;
    idle();
    cyc(); cyc();
    reset = 0;
    #1;
    chk("rst_intexc", {31'h0, IntExc}, 32'h0);
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);

    // 1: enabled interrupt on IP[12]
    We = 1; A2 = 5'd12; DIn = 32'h0000_FC01;
    cyc();
    idle(); HWInt = 6'b000100; PC_M = 32'h0000_3010;
    #1;
    chk("t1_intexc", {31'h0, IntExc}, 32'h1);
    cyc();
    rd("t1_epc", 5'd14, 32'h0000_3010);
    rd("t1_cause", 5'd13, 32'h0000_1000);
    rd("t1_sr", 5'd12, 32'h0000_FC03);
    chk("t1_intexc_after", {31'h0, IntExc}, 32'h0);

    // 2: RI in a delay slot with IE=0
    HWInt = 0; We = 1; A2 = 5'd12; DIn = 32'h0;
    cyc();
    idle(); EXCIn = 5'd10; PC_M = 32'h0000_3024; BD_M = 1;
    #1;
    chk("t2_intexc", {31'h0, IntExc}, 32'h1);
    cyc();
    idle();
    rd("t2_epc", 5'd14, 32'h0000_3020);
    rd("t2_cause", 5'd13, 32'h8000_0028);

    // 3: interrupt beats simultaneous exception
    We = 1; A2 = 5'd12; DIn = 32'h0000_0401;
    cyc();
    idle(); HWInt = 6'b000001; EXCIn = 5'd4; PC_M = 32'h0000_3100;
    #1;
    chk("t3_intexc", {31'h0, IntExc}, 32'h1);
    cyc();
    idle();
    rd("t3_cause", 5'd13, 32'h0000_0400);
    rd("t3_epc", 5'd14, 32'h0000_3100);

    // 4: EXL masks everything; eret (with SR write) re-opens the window
    EXCIn = 5'd12; HWInt = 6'h3F; PC_M = 32'h0000_3150;
    #1;
    chk("t4_masked", {31'h0, IntExc}, 32'h0);
    cyc();
    rd("t4_epc_hold", 5'd14, 32'h0000_3100);
    rd("t4_cause_hold", 5'd13, 32'h0000_FC00);
    EXCIn = 0; EXLClr = 1; We = 1; A2 = 5'd12; DIn = 32'h0000_0403;
    cyc();
    idle(); PC_M = 32'h0000_3200;
    rd("t4_sr_after_eret", 5'd12, 32'h0000_0401);
    chk("t4_reint", {31'h0, IntExc}, 32'h1);
    cyc();
    rd("t4_epc_new", 5'd14, 32'h0000_3200);

    // 5: mtc0 EPC, read-before-write, then suppression by exception
    HWInt = 0; We = 1; A2 = 5'd14; DIn = 32'h0000_3047;
    rd("t5_old_epc", 5'd14, 32'h0000_3200);
    cyc();
    idle();
    chk("t5_epc_port", EPC, 32'h0000_3044);
    EXLClr = 1;
    cyc();
    EXLClr = 0; We = 1; A2 = 5'd14; DIn = 32'h0000_3047; EXCIn = 5'd4; PC_M = 32'h0000_3300;
    #1;
    chk("t5_intexc", {31'h0, IntExc}, 32'h1);
    cyc();
    idle();
    chk("t5_suppressed", EPC, 32'h0000_3300);

    // 6: PRId, unmapped read, Cause write ignored
    rd("t6_prid", 5'd15, 32'h4C55_0007);
    rd("t6_unmapped", 5'd3, 32'h0);
    We = 1; A2 = 5'd13; DIn = 32'hFFFF_FFFF; HWInt = 6'b101010;
    cyc();
    idle();
    rd("t6_cause", 5'd13, 32'h0000_A810);

    // Reset while in the handler
    HWInt = 0; reset = 1;
    cyc();
    reset = 0;
    rd("rst2_sr", 5'd12, 32'h0);
    rd("rst2_cause", 5'd13, 32'h0);
    chk("rst2_epc", EPC, 32'h0);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor 0 for the 5-stage MIPS pipeline. It sits at the M stage and is the receiving end of the M pipeline register's exception fields (exception code, branch-delay flag, PC).
- It holds SR, Cause, EPC and PRId, and arbitrates hardware interrupts against synchronous exceptions.
- It drives the IntExc flush request back into the pipeline registers and supplies EPC for eret.
- It also services mfc0/mtc0 reads and writes.

Parameters:
- PRID, 32'h4C55_0007, constant value returned when reading PRId (reg 15).
- PC_ALIGN_MASK, 32'hFFFF_FFFC, mask applied to every value written into EPC.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all CP0 state at posedge.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data (RT value from M).
- We  in  1  mtc0 write enable (mtc0 in M stage).
- PC_M  in  32  PC of the instruction currently in M.
- BD_M  in  1  instruction in M sits in a branch delay slot.
- EXCIn  in  5  pending exception code from M pipereg; 0 = none.
- HWInt  in  6  external hardware interrupt lines, level-sensitive.
- EXLClr  in  1  eret in M: clear SR.EXL.
- IntExc  out  1  combinational: take interrupt/exception this cycle (flushes pipeline regs, selects handler PC).
- EPC  out  32  current EPC register value.
- DOut  out  32  combinational read data for A1.

Behaviour:
- Register map:
  - SR (12): IM = [15:10], EXL = [1], IE = [0]; other bits read 0.
  - Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]; other bits read 0.
  - EPC (14).
  - PRId (15) returns the PRID parameter.
  - Any other A1 returns 32'h0.
- Reset (posedge, reset = 1): IM = 0, EXL = 0, IE = 0, BD = 0, IP = 0, ExcCode = 0, EPC = 0. Consequently IntExc = 0, EPC = 0, and DOut is 0 for regs 12/13/14.
- IntReq = (|(HWInt & IM)) & IE & ~EXL.
- ExcReq = (EXCIn != 0) & ~EXL.
- IntExc = IntReq | ExcReq. Purely combinational, with zero latency, so the pipeline registers flush at the same edge the CP0 state updates.
- At posedge when IntExc = 1:
  - EXL <= 1.
  - BD <= BD_M.
  - EPC <= (BD_M ? PC_M - 4 : PC_M) & PC_ALIGN_MASK.
  - ExcCode <= IntReq ? 5'd0 : EXCIn. An interrupt has priority over a simultaneous exception.
- IP <= HWInt on every non-reset posedge, regardless of IntExc. Software cannot write IP.
- mtc0 (We = 1, IntExc = 0):
  - A2 = 12 writes IM/EXL/IE from DIn[15:10], DIn[1], DIn[0].
  - A2 = 14 writes EPC <= DIn & PC_ALIGN_MASK.
  - A2 = 13, 15 or any other value is ignored.
- EXLClr = 1 and IntExc = 0: EXL <= 0 at posedge. If We also targets SR, EXLClr wins for the EXL bit; the IM/IE bits are still written.
- Simultaneous events: IntExc = 1 suppresses both the mtc0 write and EXLClr in that cycle. The faulting or interrupted instruction must not commit CP0 side effects.
- While EXL = 1, IntExc stays 0 regardless of HWInt or EXCIn. Nested exceptions are not taken.
- Read/write same cycle: DOut reflects the pre-edge register value; there is no internal bypass. The M-stage forwarding unit owns hazards.
- EPC port always shows the register, so eret in M sees the committed value.
- Reset asserted mid-handler (EXL = 1) returns all state to reset values at the next posedge.

Test Plan:
1. Reset, then mtc0 SR = 32'h0000_FC01 and raise HWInt = 6'b000100 with PC_M = 32'h0000_3010, BD_M = 0 -> IntExc = 1 same cycle. Next cycle: EPC = 32'h0000_3010, Cause = 32'h0000_1000 (ExcCode 0, IP[12]), SR.EXL = 1, IntExc = 0.
2. SR.IE = 0, EXCIn = 5'd10 (RI), PC_M = 32'h0000_3024, BD_M = 1 -> IntExc = 1 despite IE = 0. Next cycle: EPC = 32'h0000_3020, Cause[31] = 1, Cause[6:2] = 10.
3. IE = 1 with IM[10] set, HWInt[0] = 1 and EXCIn = 5'd4 in the same cycle -> ExcCode = 0 (interrupt wins), EPC = PC_M.
4. EXL = 1, EXCIn = 5'd12 and HWInt = 6'h3F -> IntExc = 0 and no change to EPC or Cause.ExcCode. Then EXLClr = 1 for one cycle -> SR.EXL = 0, and the pending HWInt immediately drives IntExc = 1.
5. We = 1, A2 = 14, DIn = 32'h0000_3047 with IntExc = 0 -> EPC = 32'h0000_3044, and DOut for A1 = 14 shows the old value until the edge. Repeat the same write while EXCIn = 5'd4 -> write suppressed and EPC = PC_M.
6. A1 = 15 -> DOut = 32'h4C55_0007. A1 = 3 -> DOut = 0. mtc0 to Cause with DIn = 32'hFFFF_FFFF -> Cause unchanged except IP tracks HWInt.
